// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline-stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Replicated to the control width wherever a bubble is inserted.
    localparam logic PIPE_BUBBLE_CTRL = 1'b0;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with increment enable; holds at all-ones.
module pipe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [CNT_W-1:0] cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc_en) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register with valid/ready handshake, flush and bubble insertion.
// Define PIPE_SKID_EN for a two-entry skid buffer with a purely registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state_p0;
    logic [CTRL_W-1:0] main_ctrl_p0;
    logic [DATA_W-1:0] main_data_p0;
    logic              in_xfer;
    logic              out_xfer;
    logic              stall_inc;

    assign out_valid = (state_p0 != EMPTY);
    assign out_xfer  = out_valid && out_ready;

`ifdef PIPE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl_p0;
    logic [DATA_W-1:0] skid_data_p0;

    assign in_ready = (state_p0 != FULL);
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign in_xfer = in_valid && in_ready;

    // ---- stage boundary: main register, drives the outputs ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p0     <= EMPTY;
            main_ctrl_p0 <= '0;
            main_data_p0 <= '0;
        end else if (flush) begin
            state_p0     <= EMPTY;
            main_ctrl_p0 <= {CTRL_W{PIPE_BUBBLE_CTRL}};
        end else begin
            case (state_p0)
                EMPTY: begin
                    if (in_xfer) begin
                        state_p0     <= HALF;
                        main_ctrl_p0 <= in_ctrl;
                        main_data_p0 <= in_data;
                    end
                end
                HALF: begin
                    if (in_xfer && out_xfer) begin
                        main_ctrl_p0 <= in_ctrl;
                        main_data_p0 <= in_data;
                    end else if (out_xfer) begin
                        state_p0 <= EMPTY;
`ifdef PIPE_SKID_EN
                    end else if (in_xfer) begin
                        state_p0 <= FULL;
`endif
                    end
                end
`ifdef PIPE_SKID_EN
                FULL: begin
                    if (out_xfer) begin
                        state_p0     <= HALF;
                        main_ctrl_p0 <= skid_ctrl_p0;
                        main_data_p0 <= skid_data_p0;
                    end
                end
`endif
                default: state_p0 <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_SKID_EN
    // ---- stage boundary: skid register, catches the transfer in flight while main stalls ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_ctrl_p0 <= '0;
            skid_data_p0 <= '0;
        end else if (flush) begin
            skid_ctrl_p0 <= {CTRL_W{PIPE_BUBBLE_CTRL}};
        end else if (state_p0 == HALF && in_xfer && !out_xfer) begin
            skid_ctrl_p0 <= in_ctrl;
            skid_data_p0 <= in_data;
        end
    end
`endif

    assign out_ctrl  = out_valid ? main_ctrl_p0 : {CTRL_W{PIPE_BUBBLE_CTRL}};
    assign out_data  = main_data_p0;
    assign stall_inc = out_valid && !out_ready;

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (stall_inc),
        .cnt    (stall_cnt)
    );

endmodule
